memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
// - Shares the single-ported RAM between the per-CPU icache and dcache request ports (ccif side).
// - Sits between the caches and the RAM model. Grants one word transaction at a time.
// - Drives per-requester wait/load back to the caches.
// - Data requests win over instruction requests. dcache writeback and flush words are serviced like any other word.
// PARAMETERS
// - CPUS    2   number of CPUs; each CPU owns one icache port and one dcache port
// - ADDR_W  32  RAM word address width, byte address, [1:0] ignored
// - DATA_W  32  RAM data width
// PORTS
// - CLK       in   1             system clock; all state updates on posedge
// - RST       in   1             asynchronous, active-high reset
// - iREN      in   CPUS          icache read request, per CPU
// - iaddr     in   CPUS*ADDR_W   icache address
// - dREN      in   CPUS          dcache read request
// - dWEN      in   CPUS          dcache write request; dWEN has priority over dREN on the same port
// - daddr     in   CPUS*ADDR_W   dcache address
// - dstore    in   CPUS*DATA_W   dcache write data
// - iwait     out  CPUS          1 = icache request not complete; 1 whenever iREN is high and not completing
// - dwait     out  CPUS          1 = dcache request not complete
// - iload     out  CPUS*DATA_W   ramload routed to the granted icache, else 0
// - dload     out  CPUS*DATA_W   ramload routed to the granted dcache, else 0
// - ramREN    out  1             RAM read strobe
// - ramWEN    out  1             RAM write strobe
// - ramaddr   out  ADDR_W        RAM address from the granted requester
// - ramstore  out  DATA_W        RAM write data from the granted dcache
// - ramload   in   DATA_W        RAM read data
// - ramstate  in   2             RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
// BEHAVIOUR
// - Requesters are indexed 0..2*CPUS-1: d0..d(CPUS-1) first, then i0..i(CPUS-1).
// - Ownership is held in registers: owner (index) and state.
// - FSM ARB_IDLE:
//   - If any request is present, latch the winner into owner and go to ARB_BUSY.
//   - ramREN/ramWEN = 0.
//   - All asserted waits = 1.
// - FSM ARB_BUSY:
//   - Drive ramREN/ramWEN/ramaddr/ramstore from the owner.
//   - On ramstate==ACCESS: deassert the owner's wait combinationally in that cycle, route ramload to the owner's load, go to ARB_IDLE.
//   - On FREE/BUSY: stay.
//   - On ERROR: stay. Hold the owner's wait=1. Reissue the access.
// - FSM ARB_DONE is not used. Re-arbitration happens in the ARB_IDLE cycle after completion. Minimum latency per word is 2 cycles (grant + ACCESS).
// - Request drop: if the owner deasserts its request while in ARB_BUSY, go to ARB_IDLE the next cycle. RAM strobes deassert at once (combinational gating on the owner's request). No wait pulse.
// - A dcache changing between dREN and dWEN while owning is a protocol error. The arbiter follows the current strobes and asserts `SVA (sim only).
// - Simultaneous requests in ARB_IDLE:
//   - Any dcache beats any icache.
//   - Among same-class ports, selection follows CONFIGURATION.
// - A second request from a non-owner during ARB_BUSY waits. It is never dropped.
// - Reset mid-transaction: state=ARB_IDLE, owner=0, strobes 0 immediately (asynchronous). RAM completion is ignored.
// - Reset values:
//   - ramREN = ramWEN = 0; ramaddr = ramstore = 0.
//   - iload = dload = 0.
//   - iwait/dwait = request & 1 (combinational on the request only).
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined:
//   - Per class (d, i), a last-grant pointer register rotates priority. The port after the last winner is checked first.
//   - The pointer updates on completion (ACCESS). Reset value is 0, so port 0 wins the first tie.
// - Not defined: fixed priority, lowest CPU index wins in each class. No pointer registers exist.
// STRUCTURE
// - Shared package arb_types_pkg:
//   - ramstate_t enum (FREE, BUSY, ACCESS, ERROR).
//   - arb_state_t enum (ARB_IDLE, ARB_BUSY).
//   - Requester-index width constant.
// - ramstate_t belongs in cpu_types_pkg if it is already defined there.
// - Sub-module prio_pick #(N): combinational request vector + start pointer -> one-hot grant + valid. Instantiated once for the d class and once for the i class.
// TESTING
// - Single icache read:
//   - iREN[0]=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xCAFE.
//   - Required: iwait[0] low exactly in the ACCESS cycle and iload[0]=0xCAFE.
// - Contention:
//   - iREN[0] and dREN[1] rise in the same cycle.
//   - Required: the dcache word is granted first (ramaddr=daddr[1]); the icache word is granted in the following ARB_IDLE cycle. Neither request is lost.
// - Round robin (ARB_ROUND_ROBIN_EN):
//   - dREN[0]=dREN[1]=1 continuously for 4 words.
//   - Required: grant order is 0,1,0,1.
//   - Without the macro the order is 0,0,0,0.
// - Write path:
//   - dWEN[0]=1, daddr=0x100, dstore=0xDEADBEEF.
//   - Required: ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF. dwait[0] drops on ACCESS. ramREN stays 0 throughout.
// - Error and drop:
//   - ramstate=ERROR for 3 cycles, then ACCESS. Required: dwait stays 1 through ERROR and completes once.
//   - Separately, the owner drops its request mid-BUSY. Required: strobes drop the same cycle and the FSM returns to ARB_IDLE.
// - Reset mid-transaction:
//   - Assert RST while in ARB_BUSY with ramREN=1.
//   - Required: ramREN=0 asynchronously, FSM in ARB_IDLE. The first post-reset grant goes to port 0.

Source files
------------

// File: rtl/arb_types_pkg.sv
// Shared types for the memory arbiter.
//   ramstate_t  : RAM status as reported by the RAM model (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t : arbiter FSM states
//   REQ_IDX_W   : requester-index width for the default two-CPU build
//   idx_w()     : index width for n entries, never less than 1 bit
package arb_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned REQ_IDX_W = 2;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Rotating priority picker. The first requester found when scanning upward from
// start (wrapping past N-1 back to 0) is granted.
//   req   in  N   request vector
//   start in  PW  index checked first
//   gnt   out N   one-hot grant
//   valid out 1   any request present
module prio_pick
  import arb_types_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  // Two passes: indices at/above start first, then the wrapped-around ones.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int j = 0; j < int'(N); j++) begin
      if (!valid && req[j] && (j >= int'(start))) begin
        gnt[j] = 1'b1;
        valid  = 1'b1;
      end
    end
    for (int j = 0; j < int'(N); j++) begin
      if (!valid && req[j] && (j < int'(start))) begin
        gnt[j] = 1'b1;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between the per-CPU icache and dcache ports.
// One word transaction is owned at a time; dcache requests beat icache requests.
// Optional macro ARB_ROUND_ROBIN_EN: rotating priority inside each class
// (otherwise lowest CPU index wins).
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   iREN, iaddr         icache read requests/addresses (per CPU)
//   dREN, dWEN, daddr,  dcache read/write requests, addresses, write data
//   dstore
//   iwait, dwait        1 = request not completing this cycle
//   iload, dload        ramload routed to the completing requester, else 0
//   ramREN, ramWEN,     RAM strobes, address and write data of the owner
//   ramaddr, ramstore
//   ramload, ramstate   RAM read data and status
//
// state    | meaning
// ARB_IDLE | no owner; winner of current requests is latched into owner
// ARB_BUSY | owner drives the RAM until ACCESS, or until it drops its request
//
// Requester index: 0..CPUS-1 are dcache ports, CPUS..2*CPUS-1 icache ports.
module memory_arbiter
  import arb_types_pkg::*;
#(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*ADDR_W-1:0] iaddr,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*ADDR_W-1:0] daddr,
  input  logic [CPUS*DATA_W-1:0] dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*DATA_W-1:0] iload,
  output logic [CPUS*DATA_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [DATA_W-1:0]      ramstore,
  input  logic [DATA_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  localparam int unsigned OW = idx_w(2 * CPUS);
  localparam int unsigned PW = idx_w(CPUS);

  arb_state_t      state, state_nxt;
  logic [OW-1:0]   owner, owner_nxt;
  logic [CPUS-1:0] dreq, d_gnt, i_gnt;
  logic            d_vld, i_vld;
  logic [PW-1:0]   d_start, i_start, d_sel, i_sel;
  logic            own_d, own_req, own_wen;
  logic [PW-1:0]   own_idx;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_store;

  assign dreq    = dREN | dWEN;
  assign own_d   = (owner < OW'(CPUS));
  assign own_idx = own_d ? PW'(owner) : PW'(owner - OW'(CPUS));

  // Owner's request, strobe direction, address and data.
  always_comb begin
    own_req   = 1'b0;
    own_wen   = 1'b0;
    own_addr  = '0;
    own_store = '0;
    for (int k = 0; k < int'(CPUS); k++) begin
      if (PW'(k) == own_idx) begin
        if (own_d) begin
          own_req   = dreq[k];
          own_wen   = dWEN[k];
          own_addr  = daddr[k*ADDR_W +: ADDR_W];
          own_store = dstore[k*DATA_W +: DATA_W];
        end else begin
          own_req  = iREN[k];
          own_addr = iaddr[k*ADDR_W +: ADDR_W];
        end
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Pointers hold the index checked first; after a completion they move to
  // the port following the winner.
  logic [PW-1:0] d_ptr, i_ptr;
  logic          done;

  assign done = (state == ARB_BUSY) && own_req && (ramstate_t'(ramstate) == ACCESS);

  function automatic logic [PW-1:0] after(input logic [PW-1:0] p);
    return (p == PW'(CPUS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d_ptr <= '0;
      i_ptr <= '0;
    end else if (done) begin
      if (own_d) d_ptr <= after(own_idx);
      else       i_ptr <= after(own_idx);
    end
  end

  assign d_start = d_ptr;
  assign i_start = i_ptr;
`else
  assign d_start = '0;
  assign i_start = '0;
`endif

  prio_pick #(.N(CPUS), .PW(PW)) u_pick_d (
    .req(dreq), .start(d_start), .gnt(d_gnt), .valid(d_vld)
  );

  prio_pick #(.N(CPUS), .PW(PW)) u_pick_i (
    .req(iREN), .start(i_start), .gnt(i_gnt), .valid(i_vld)
  );

  always_comb begin
    d_sel = '0;
    i_sel = '0;
    for (int k = 0; k < int'(CPUS); k++) begin
      if (d_gnt[k]) d_sel = PW'(k);
      if (i_gnt[k]) i_sel = PW'(k);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ARB_IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    dwait     = dreq;
    iwait     = iREN;
    dload     = '0;
    iload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (state)
      ARB_IDLE: begin
        if (d_vld) begin
          owner_nxt = OW'(d_sel);
          state_nxt = ARB_BUSY;
        end else if (i_vld) begin
          owner_nxt = OW'(i_sel) + OW'(CPUS);
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!own_req) begin
          // Owner withdrew: strobes already gated off, release next cycle.
          state_nxt = ARB_IDLE;
        end else begin
          ramWEN   = own_wen;
          ramREN   = !own_wen;
          ramaddr  = own_addr;
          ramstore = own_d ? own_store : '0;
          // ERROR keeps the strobes up so the RAM sees the access again.
          if (ramstate_t'(ramstate) == ACCESS) begin
            state_nxt = ARB_IDLE;
            for (int k = 0; k < int'(CPUS); k++) begin
              if (PW'(k) == own_idx) begin
                if (own_d) begin
                  dwait[k]                  = 1'b0;
                  dload[k*DATA_W +: DATA_W] = ramload;
                end else begin
                  iwait[k]                  = 1'b0;
                  iload[k*DATA_W +: DATA_W] = ramload;
                end
              end
            end
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

`ifndef SYNTHESIS
  // A dcache must not flip between read and write while it owns the RAM.
  a_dir_stable: assert property (
    @(posedge CLK) disable iff (RST)
      (state == ARB_BUSY && own_d && own_req && $past(state == ARB_BUSY && own_req))
        |-> $stable(own_wen)
  );
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import arb_types_pkg::*;

  localparam int CPUS = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [CPUS-1:0]      iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS*AW-1:0]   iaddr, daddr;
  logic [CPUS*DW-1:0]   dstore, iload, dload;
  logic                 ramREN, ramWEN;
  logic [AW-1:0]        ramaddr;
  logic [DW-1:0]        ramstore, ramload;
  logic [1:0]           ramstate;

  typedef struct {
    bit          is_d;
    int          port;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } item_t;

  item_t sb[$];
  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  memory_arbiter #(.CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic void exp_word(input bit is_d, input int port, input logic [31:0] addr,
                                   input bit we, input logic [31:0] wdata,
                                   input logic [31:0] rdata);
    item_t it;
    it.is_d = is_d; it.port = port; it.addr = addr;
    it.we = we; it.wdata = wdata; it.rdata = rdata;
    sb.push_back(it);
  endfunction

  function automatic logic port_wait(input item_t it);
    return it.is_d ? dwait[it.port] : iwait[it.port];
  endfunction

  function automatic logic [31:0] port_load(input item_t it);
    return it.is_d ? dload[it.port*DW +: DW] : iload[it.port*DW +: DW];
  endfunction

  // RAM responder: waits for a grant, answers with lat BUSY and nerr ERROR
  // cycles, then ACCESS; checks the completion against the scoreboard head.
  task automatic serve(input int lat, input int nerr, input string tag, output int waited);
    item_t it;
    waited = 0;
    while (!(ramREN | ramWEN) && waited < 20) begin
      step();
      waited++;
    end
    if (!(ramREN | ramWEN)) begin
      chk({tag, "_grant_timeout"}, 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, 0, 1);
      return;
    end
    it = sb.pop_front();
    for (int c = 0; c < lat + nerr; c++) begin
      ramstate = (c < lat) ? BUSY : ERROR;
      #4;
      chk({tag, "_wait_held"}, port_wait(it), 1);
      chk({tag, "_ren_hold"}, ramREN, !it.we);
      step();
    end
    ramstate = ACCESS;
    ramload  = it.rdata;
    #4;
    chk({tag, "_addr"}, ramaddr, it.addr);
    chk({tag, "_ren"}, ramREN, !it.we);
    chk({tag, "_wen"}, ramWEN, it.we);
    if (it.we) chk({tag, "_store"}, ramstore, it.wdata);
    chk({tag, "_wait_low"}, port_wait(it), 0);
    chk({tag, "_load"}, port_load(it), it.rdata);
    step();
    ramstate = FREE;
    ramload  = '0;
  endtask

  initial begin
    int w;
    RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #2 iREN = 2'b10;
    #1;
    chk("rst_ramren", ramREN, 0);
    chk("rst_ramwen", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_iwait", iwait, 2'b10);
    chk("rst_dwait", dwait, 2'b00);
    iREN = '0;
    step(); step();
    RST = 1'b0;
    step();

    // single icache read, 2 BUSY cycles
    iaddr[31:0] = 32'h40;
    iREN[0] = 1'b1;
    exp_word(0, 0, 32'h40, 0, 32'h0, 32'hCAFE);
    serve(2, 0, "iread", w);
    chk("iread_grant_lat", w, 1);
    iREN[0] = 1'b0;
    step();

    // contention: dcache 1 before icache 0
    iaddr[31:0] = 32'h60;
    daddr[63:32] = 32'h1000;
    iREN[0] = 1'b1;
    dREN[1] = 1'b1;
    exp_word(1, 1, 32'h1000, 0, 32'h0, 32'h1111);
    exp_word(0, 0, 32'h60, 0, 32'h0, 32'h2222);
    serve(1, 0, "cont_d", w);
    chk("cont_i_still_wait", iwait[0], 1);
    dREN[1] = 1'b0;
    serve(1, 0, "cont_i", w);
    chk("cont_i_regrant_lat", w, 1);
    iREN[0] = 1'b0;
    step();

    // both dcaches continuously for 4 words, from reset priority state
    RST = 1'b1;
    step();
    RST = 1'b0;
    daddr[31:0]  = 32'h200;
    daddr[63:32] = 32'h300;
    dREN = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (k % 2 == 0) exp_word(1, 0, 32'h200, 0, 32'h0, 32'hA0 + k);
      else            exp_word(1, 1, 32'h300, 0, 32'h0, 32'hA0 + k);
`else
      exp_word(1, 0, 32'h200, 0, 32'h0, 32'hA0 + k);
`endif
    end
    for (int k = 0; k < 4; k++) serve(0, 0, "rr", w);
    dREN = '0;
    step();

    // write path
    daddr[31:0]  = 32'h100;
    dstore[31:0] = 32'hDEADBEEF;
    dWEN[0] = 1'b1;
    exp_word(1, 0, 32'h100, 1, 32'hDEADBEEF, 32'h0);
    serve(2, 0, "wr", w);
    dWEN[0] = 1'b0;
    step();

    // ERROR for 3 cycles, then ACCESS; must complete once
    daddr[31:0] = 32'h80;
    dREN[0] = 1'b1;
    exp_word(1, 0, 32'h80, 0, 32'h0, 32'h5A5A);
    serve(0, 3, "err", w);
    dREN[0] = 1'b0;
    step();
    chk("err_no_reissue_a", ramREN | ramWEN, 0);
    step();
    chk("err_no_reissue_b", ramREN | ramWEN, 0);

    // owner drops mid-BUSY
    iaddr[63:32] = 32'h44;
    iREN[1] = 1'b1;
    step();
    chk("drop_granted", ramREN, 1);
    ramstate = BUSY;
    step();
    iREN[1] = 1'b0;
    #1;
    chk("drop_ren_now", ramREN, 0);
    chk("drop_iwait", iwait[1], 0);
    step();
    ramstate = FREE;
    daddr[31:0] = 32'h90;
    dREN[0] = 1'b1;
    exp_word(1, 0, 32'h90, 0, 32'h0, 32'h77);
    serve(0, 0, "drop_next", w);
    chk("drop_idle_lat", w, 1);
    dREN[0] = 1'b0;
    step();

    // reset mid-transaction
    daddr[63:32] = 32'h500;
    dREN[1] = 1'b1;
    step();
    ramstate = BUSY;
    chk("rstmid_pre_ren", ramREN, 1);
    #2 RST = 1'b1;
    #1;
    chk("rstmid_async_ren", ramREN, 0);
    chk("rstmid_dwait", dwait[1], 1);
    daddr[31:0] = 32'h600;
    dREN[0] = 1'b1;
    ramstate = ACCESS;
    ramload = 32'hBAD;
    step();
    ramstate = FREE;
    ramload = '0;
    RST = 1'b0;
    exp_word(1, 0, 32'h600, 0, 32'h0, 32'h61);
    exp_word(1, 1, 32'h500, 0, 32'h0, 32'h51);
    serve(0, 0, "post_rst0", w);
    chk("post_rst_lat", w, 1);
    dREN[0] = 1'b0;
    serve(0, 0, "post_rst1", w);
    dREN[1] = 1'b0;
    step();
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
